// File: rtl/weight_dma_sequencer.sv
// Streams conv and FC weights from ITCM into the conv SRAM and four striped FC banks.
// Each cycle issues one ITCM read; the returned word is written one cycle later.
module weight_dma_sequencer #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_dma_start,
  input  logic [AW-1:0] i_conv_weight_length,
  input  logic [AW-1:0] i_fc_weight_length,
  output logic [AW-1:0] o_itcm_addr,
  input  logic [DW-1:0] i_itcm_data,
  output logic          o_write_en,
  output logic [4:0]    o_dma_control,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy,
  output logic          o_dma_finish
);

  localparam int unsigned CW = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_FC,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] conv_len_q, conv_len_d;
  logic [AW-1:0] fc_len_q, fc_len_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] itcm_addr_q, itcm_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0] ctrl_q, ctrl_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
  logic [AW-1:0] conv_last;
  logic [AW-1:0] fc_last;

  assign conv_last = AW'(conv_len_q - AW'(1));
  assign fc_last   = AW'(fc_len_q - AW'(1));

  // Next-state, read address and write-strobe generation.
  always_comb begin
    state_d     = state_q;
    conv_len_d  = conv_len_q;
    fc_len_d    = fc_len_q;
    cnt_d       = cnt_q;
    itcm_addr_d = itcm_addr_q;
    we_d        = 1'b0;
    ctrl_d      = '0;
    wr_addr_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_dma_start) begin
          conv_len_d = i_conv_weight_length;
          fc_len_d   = i_fc_weight_length;
          cnt_d      = '0;
          if (i_conv_weight_length != '0) begin
            state_d     = ST_CONV;
            itcm_addr_d = '0;
          end else if (i_fc_weight_length != '0) begin
            state_d     = ST_FC;
            itcm_addr_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_CONV: begin
        if (!i_dma_start) begin
          state_d = ST_IDLE;
        end else begin
          we_d      = 1'b1;
          ctrl_d    = CW'(1);
          wr_addr_d = cnt_q;
          if (cnt_q == conv_last) begin
            cnt_d = '0;
            // Roll straight into FC so the read stream has no bubble.
            if (fc_len_q != '0) begin
              state_d     = ST_FC;
              itcm_addr_d = AW'(itcm_addr_q + AW'(1));
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            cnt_d       = AW'(cnt_q + AW'(1));
            itcm_addr_d = AW'(itcm_addr_q + AW'(1));
          end
        end
      end
      ST_FC: begin
        if (!i_dma_start) begin
          state_d = ST_IDLE;
        end else begin
          we_d      = 1'b1;
          ctrl_d    = CW'(CW'(2) << cnt_q[1:0]);
          wr_addr_d = AW'(cnt_q >> 2);
          if (cnt_q == fc_last) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d       = AW'(cnt_q + AW'(1));
            itcm_addr_d = AW'(itcm_addr_q + AW'(1));
          end
        end
      end
      ST_DRAIN: begin
        state_d = i_dma_start ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        if (!i_dma_start) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CONV) || (state_d == ST_FC) || (state_d == ST_DRAIN);
    fin_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      conv_len_q  <= '0;
      fc_len_q    <= '0;
      cnt_q       <= '0;
      itcm_addr_q <= '0;
      wr_addr_q   <= '0;
      ctrl_q      <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_len_q  <= conv_len_d;
      fc_len_q    <= fc_len_d;
      cnt_q       <= cnt_d;
      itcm_addr_q <= itcm_addr_d;
      wr_addr_q   <= wr_addr_d;
      ctrl_q      <= ctrl_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
    end
  end

  // ITCM data arrives in the write cycle itself, so write data passes straight through.
  assign o_wr_data     = we_q ? i_itcm_data : '0;
  assign o_itcm_addr   = itcm_addr_q;
  assign o_write_en    = we_q;
  assign o_dma_control = ctrl_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_busy        = busy_q;
  assign o_dma_finish  = fin_q;

endmodule

// File: tb/tb_weight_dma_sequencer.sv
// Directed bench for weight_dma_sequencer with a one-cycle-latency ITCM returning addr+100.
module tb_weight_dma_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] conv_len;
  logic [15:0] fc_len;
  logic [15:0] itcm_addr;
  logic [15:0] itcm_data;
  logic        we;
  logic [4:0]  ctrl;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        fin;

  int n_checks = 0;
  int n_fail   = 0;

  logic [55:0] obs;
  assign obs = {we, ctrl, wr_addr, wr_data, busy, fin, itcm_addr};

  weight_dma_sequencer #(.DW(16), .AW(16)) dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_dma_start          (start),
    .i_conv_weight_length (conv_len),
    .i_fc_weight_length   (fc_len),
    .o_itcm_addr          (itcm_addr),
    .i_itcm_data          (itcm_data),
    .o_write_en           (we),
    .o_dma_control        (ctrl),
    .o_wr_addr            (wr_addr),
    .o_wr_data            (wr_data),
    .o_busy               (busy),
    .o_dma_finish         (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) itcm_data <= itcm_addr + 16'd100;

  function automatic logic [55:0] pk(input logic w, input logic [4:0] c, input logic [15:0] wa,
                                     input logic [15:0] wd, input logic b, input logic f,
                                     input logic [15:0] a);
    return {w, c, wa, wd, b, f, a};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [55:0] exp_v;
    rst_n = 1'b1; start = 1'b0; conv_len = 16'd0; fc_len = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL reset_async: got %h exp %h", obs, exp_v); n_fail++;
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL reset_idle: got %h exp %h", obs, exp_v); n_fail++;
    end
  endtask

  task automatic test_zero_len();
    logic [55:0] exp_v;
    conv_len = 16'd0; fc_len = 16'd0; start = 1'b1;
    step();
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd0);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL zero_done: got %h exp %h", obs, exp_v); n_fail++;
    end
    start = 1'b0;
    step();
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL zero_idle: got %h exp %h", obs, exp_v); n_fail++;
    end
    // Restart right after DONE exited: one conv word.
    start = 1'b1; conv_len = 16'd1; fc_len = 16'd0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      step();
      case (cyc)
        1:       exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b1, 1'b0, 16'd0);
        2:       exp_v = pk(1'b1, 5'd1, 16'd0, 16'd100, 1'b1, 1'b0, 16'd0);
        default: exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b0, 1'b1, 16'd0);
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL restart cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic run_basic_seq(input string tag);
    logic [55:0] exp_v;
    conv_len = 16'd2; fc_len = 16'd5; start = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      if (cyc == 2) begin
        conv_len = 16'd7; fc_len = 16'd7;
      end
      case (cyc)
        1:       exp_v = pk(1'b0, 5'd0,  16'd0, 16'd0,   1'b1, 1'b0, 16'd0);
        2:       exp_v = pk(1'b1, 5'd1,  16'd0, 16'd100, 1'b1, 1'b0, 16'd1);
        3:       exp_v = pk(1'b1, 5'd1,  16'd1, 16'd101, 1'b1, 1'b0, 16'd2);
        4:       exp_v = pk(1'b1, 5'd2,  16'd0, 16'd102, 1'b1, 1'b0, 16'd3);
        5:       exp_v = pk(1'b1, 5'd4,  16'd0, 16'd103, 1'b1, 1'b0, 16'd4);
        6:       exp_v = pk(1'b1, 5'd8,  16'd0, 16'd104, 1'b1, 1'b0, 16'd5);
        7:       exp_v = pk(1'b1, 5'd16, 16'd0, 16'd105, 1'b1, 1'b0, 16'd6);
        8:       exp_v = pk(1'b1, 5'd2,  16'd1, 16'd106, 1'b1, 1'b0, 16'd6);
        default: exp_v = pk(1'b0, 5'd0,  16'd0, 16'd0,   1'b0, 1'b1, 16'd6);
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL %s cyc%0d: got %h exp %h", tag, cyc, obs, exp_v); n_fail++;
      end
    end
    start = 1'b0;
    step();
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd6);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL %s idle: got %h exp %h", tag, obs, exp_v); n_fail++;
    end
  endtask

  task automatic test_basic();
    run_basic_seq("basic");
  endtask

  task automatic test_conv_only();
    logic [55:0] exp_v;
    conv_len = 16'd3; fc_len = 16'd0; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      case (cyc)
        1:       exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b1, 1'b0, 16'd0);
        2:       exp_v = pk(1'b1, 5'd1, 16'd0, 16'd100, 1'b1, 1'b0, 16'd1);
        3:       exp_v = pk(1'b1, 5'd1, 16'd1, 16'd101, 1'b1, 1'b0, 16'd2);
        4:       exp_v = pk(1'b1, 5'd1, 16'd2, 16'd102, 1'b1, 1'b0, 16'd2);
        default: exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b0, 1'b1, 16'd2);
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL conv_only cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic [55:0] exp_v;
    conv_len = 16'd4; fc_len = 16'd8; start = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      step();
      case (cyc)
        1:       exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b1, 1'b0, 16'd0);
        2:       exp_v = pk(1'b1, 5'd1, 16'd0, 16'd100, 1'b1, 1'b0, 16'd1);
        3:       exp_v = pk(1'b1, 5'd1, 16'd1, 16'd101, 1'b1, 1'b0, 16'd2);
        4:       exp_v = pk(1'b1, 5'd1, 16'd2, 16'd102, 1'b1, 1'b0, 16'd3);
        default: exp_v = pk(1'b1, 5'd1, 16'd3, 16'd103, 1'b1, 1'b0, 16'd4);
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL abort cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
    start = 1'b0;
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd4);
    for (int cyc = 6; cyc <= 8; cyc++) begin
      step();
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL abort_drop cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
  endtask

  task automatic test_done_hold();
    logic [55:0] exp_v;
    conv_len = 16'd1; fc_len = 16'd1; start = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      step();
      case (cyc)
        1:       exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0,   1'b1, 1'b0, 16'd0);
        2:       exp_v = pk(1'b1, 5'd1, 16'd0, 16'd100, 1'b1, 1'b0, 16'd1);
        default: exp_v = pk(1'b1, 5'd2, 16'd0, 16'd101, 1'b1, 1'b0, 16'd1);
      endcase
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL done_run cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b1, 16'd1);
    for (int cyc = 4; cyc <= 13; cyc++) begin
      step();
      n_checks++;
      if (obs !== exp_v) begin
        $display("FAIL done_hold cyc%0d: got %h exp %h", cyc, obs, exp_v); n_fail++;
      end
    end
    start = 1'b0;
    step();
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd1);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL done_exit: got %h exp %h", obs, exp_v); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    logic [55:0] exp_v;
    conv_len = 16'd2; fc_len = 16'd5; start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) step();
    exp_v = pk(1'b1, 5'd2, 16'd0, 16'd102, 1'b1, 1'b0, 16'd3);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL midfc_pre: got %h exp %h", obs, exp_v); n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = pk(1'b0, 5'd0, 16'd0, 16'd0, 1'b0, 1'b0, 16'd0);
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL midfc_reset: got %h exp %h", obs, exp_v); n_fail++;
    end
    start = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (obs !== exp_v) begin
      $display("FAIL post_reset_idle: got %h exp %h", obs, exp_v); n_fail++;
    end
    run_basic_seq("restart");
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_basic();
    test_conv_only();
    test_abort();
    test_done_hold();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
